tv_sequencer: RTL and testbench
===============================

Name: tv_sequencer

Overview:
- Synthesizable test-vector engine that stimulates a unit under test (UUT) and checks its outputs.
- Reads packed vectors {valid, stimulus, expected} from a synchronous vector ROM, drives the stimulus to the UUT, waits a fixed UUT latency, compares the UUT response, and accumulates pass/fail status.
- Used for on-FPGA self-check of datapath units (ALU, register file read path, decoder) with the same `.tv` vector content used in simulation.

Parameters:
- IN_W, 64, total UUT stimulus width in bits.
- OUT_W, 32, UUT response width in bits.
- TV_LEN, 100, ROM depth; maximum number of vectors.
- ADDR_W, 7, ROM address width; must satisfy 2^ADDR_W >= TV_LEN.
- DUT_LAT, 0, UUT latency in cycles from a stable stimulus to a valid response (0 = combinational UUT).
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from vector 0.
- rom_addr  out  ADDR_W  vector ROM address.
- rom_data  in  1+IN_W+OUT_W  ROM word, valid one cycle after rom_addr. Layout: [MSB] valid, then stimulus, then expected in the LSBs.
- dut_in  out  IN_W  registered stimulus to the UUT.
- dut_out  in  OUT_W  UUT response.
- busy  out  1  high while a run is in progress.
- done  out  1  high from the end of a run until the next start.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_W  number of mismatching vectors; saturates at all-ones.
- first_err  out  ADDR_W  index of the first mismatching vector; valid when err_count!=0.
- vec_count  out  ADDR_W+1  number of vectors checked.

Behaviour:
- Reset (async assert, sync deassert assumed at the system level):
  - State=IDLE.
  - All outputs 0: rom_addr, dut_in, err_count, first_err, vec_count, busy, done, pass.
- States: IDLE, FETCH, LOAD, WAIT, DONE.
- IDLE/DONE + start: clear err_count, first_err and vec_count; idx=0; go to FETCH.
  - Start in DONE restarts the run.
  - Start while busy is ignored.
- FETCH (1 cycle): rom_addr=idx; go to LOAD.
- LOAD (1 cycle): rom_data is valid this cycle.
  - If valid bit=0: sentinel, go to DONE with no check.
  - Else on the clock edge: dut_in<=stimulus, exp_q<=expected, wait_cnt<=DUT_LAT; go to WAIT.
- WAIT:
  - If wait_cnt!=0: decrement and stay.
  - If wait_cnt==0: compare dut_out against exp_q this cycle (4-state-free equality).
    - On mismatch: err_count+=1 (saturating). If this is the first error, first_err<=idx.
    - vec_count+=1.
    - If idx==TV_LEN-1, go to DONE; else idx+=1 and go to FETCH.
- Throughput: exactly 3+DUT_LAT cycles per vector.
- busy=1 in FETCH/LOAD/WAIT.
- done=1 only in DONE; pass is combinational from done and err_count.
- dut_in holds its last value after DONE; it is not cleared.
- A sentinel at index 0 ends the run immediately: done=1, vec_count=0, pass=1.
- rst_n asserted mid-run: immediate return to IDLE with all outputs cleared. No partial results are retained.
- err_count saturation: once at all-ones it holds; first_err is still captured correctly.

Decomposition:
- Shared package/defines file:
  - State encoding constants.
  - Vector field offset macros (VALID_BIT, STIM_LSB, EXP_LSB) derived from IN_W/OUT_W.
- One natural sub-module: tv_rom, a synchronous-read ROM initialised with $readmemb from the unit's `.tv` file.
  - It is instantiated beside tv_sequencer at the top level, not inside it.

Test Plan:
- Combinational adder UUT (DUT_LAT=0), 4 vectors all correct, sentinel at index 4:
  - Required: done after 1+4×3+2 cycles from start, vec_count=4, err_count=0, pass=1.
- Same setup with vector 2 expected corrupted (0x00000005 vs UUT 0x00000004):
  - Required: err_count=1, first_err=2, pass=0.
- DUT_LAT=2 registered UUT, 3 vectors:
  - Required: dut_out sampled exactly 2 cycles after dut_in updates; 5 cycles per vector; err_count=0.
- Full ROM with no sentinel, TV_LEN=100:
  - Required: run ends after index 99, vec_count=100, rom_addr never exceeds 99.
- Sentinel at index 0:
  - Required: done 2 cycles after start, vec_count=0, pass=1.
- rst_n low during WAIT of vector 3, then start:
  - Required: all outputs 0 while in reset.
  - Required: the new run begins at index 0 with counters cleared.
  - Required: start pulsed mid-run has no effect on idx.

Source files
------------

// File: rtl/tv_sequencer_pkg.sv
// Shared definitions for the test-vector sequencer: state encoding and the
// bit offsets of the fields packed into each vector ROM word.
package tv_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StLoad  = 3'd2,
        StWait  = 3'd3,
        StDone  = 3'd4
    } tvState_e;

    // ROM word layout, MSB first: {valid, stimulus[inW-1:0], expected[outW-1:0]}
    function automatic int unsigned validBit(input int unsigned inW, input int unsigned outW);
        return inW + outW;
    endfunction

    function automatic int unsigned stimLsb(input int unsigned outW);
        return outW;
    endfunction

    localparam int unsigned EXP_LSB = 0;

endpackage

// File: rtl/tv_rom.sv
// Synchronous-read vector ROM. Contents come from the INIT image so the
// same vectors drive both simulation and the on-FPGA self-check.
module tv_rom #(
  parameter int unsigned            ADDR_W = 7,
  parameter int unsigned            WORD_W = 97,
  parameter int unsigned            DEPTH  = 100,
  parameter logic [DEPTH*WORD_W-1:0] INIT  = '0
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // ROM image: word i sits at INIT[i*WORD_W +: WORD_W]
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem[i] = INIT[i*WORD_W +: WORD_W];
    end
  end

  // Registered read; out-of-range addresses read as an all-zero (sentinel) word
  always_ff @(posedge clk) begin
    data <= (32'(addr) < DEPTH) ? mem[addr] : '0;
  end

endmodule

// File: rtl/tv_sequencer.sv
// Test-vector engine: fetches {valid, stimulus, expected} words from a
// synchronous ROM, drives the stimulus to the unit under test, waits DUT_LAT
// cycles, compares the response and accumulates pass/fail status.
module tv_sequencer
    import tv_sequencer_pkg::*;
#(
    parameter int unsigned IN_W    = 64,
    parameter int unsigned OUT_W   = 32,
    parameter int unsigned TV_LEN  = 100,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DUT_LAT = 0,
    parameter int unsigned ERR_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [IN_W+OUT_W:0]   rom_data,
    output logic [IN_W-1:0]       dut_in,
    input  logic [OUT_W-1:0]      dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [ADDR_W-1:0]     first_err,
    output logic [ADDR_W:0]       vec_count
);

    localparam int unsigned VALID_BIT = validBit(IN_W, OUT_W);
    localparam int unsigned STIM_LSB  = stimLsb(OUT_W);
    localparam int unsigned LAT_W     = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;

    tvState_e            state;
    logic [ADDR_W-1:0]   idx;
    logic [OUT_W-1:0]    expQ;
    logic [LAT_W-1:0]    waitCnt;

    logic                romValid;
    logic [IN_W-1:0]     romStim;
    logic [OUT_W-1:0]    romExp;
    logic                mismatch;
    logic                errFull;
    logic                lastIdx;

    assign romValid = rom_data[VALID_BIT];
    assign romStim  = rom_data[STIM_LSB +: IN_W];
    assign romExp   = rom_data[EXP_LSB +: OUT_W];
    assign mismatch = (dut_out != expQ);
    assign errFull  = &err_count;
    assign lastIdx  = (idx == ADDR_W'(TV_LEN - 1));

    // The ROM address is the vector index itself; it only moves on entry to FETCH
    assign rom_addr = idx;
    assign pass     = done && (err_count == '0);

    // Sequencer FSM with all status outputs registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            idx       <= '0;
            expQ      <= '0;
            waitCnt   <= '0;
            dut_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            first_err <= '0;
            vec_count <= '0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        err_count <= '0;
                        first_err <= '0;
                        vec_count <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= StFetch;
                    end
                end
                StFetch: begin
                    state <= StLoad;
                end
                StLoad: begin
                    if (!romValid) begin
                        // Sentinel word: end of the vector list, nothing to check
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        dut_in  <= romStim;
                        expQ    <= romExp;
                        waitCnt <= LAT_W'(DUT_LAT);
                        state   <= StWait;
                    end
                end
                StWait: begin
                    if (waitCnt != '0) begin
                        waitCnt <= waitCnt - LAT_W'(1);
                    end else begin
                        if (mismatch) begin
                            if (!errFull) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                            // Counter never returns to zero once hit, even when saturated
                            if (err_count == '0) begin
                                first_err <= idx;
                            end
                        end
                        vec_count <= vec_count + (ADDR_W + 1)'(1);
                        if (lastIdx) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= StFetch;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tv_sequencer.sv
// Bench for tv_sequencer: two instances (combinational UUT with DUT_LAT=0 and a
// two-stage registered UUT with DUT_LAT=2, ERR_W=2), each fed from a bench ROM.
// A cycle-indexed model derives every output from the vector list and the time
// since the accepted start; directed scenarios add hand-computed literal checks.
module tb_tv_sequencer;

    typedef struct packed {
        logic        v;
        logic [63:0] s;
        logic [31:0] e;
    } vec_t;

    typedef vec_t rom_t [100];

    typedef struct packed {
        logic [6:0]  addr;
        logic [63:0] din;
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] err;
        logic [6:0]  ferr;
        logic [7:0]  vcnt;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        startA, startB;

    logic [6:0]  romAddrA, romAddrB;
    logic [96:0] romDataA, romDataB;
    logic [63:0] dutInA, dutInB;
    logic [31:0] dutOutA, dutOutB;
    logic        busyA, busyB, doneA, doneB, passA, passB;
    logic [15:0] errA;
    logic [1:0]  errB;
    logic [6:0]  firstA, firstB;
    logic [7:0]  vecA, vecB;

    tv_sequencer #(.DUT_LAT(0)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA),
        .rom_addr(romAddrA), .rom_data(romDataA),
        .dut_in(dutInA), .dut_out(dutOutA),
        .busy(busyA), .done(doneA), .pass(passA),
        .err_count(errA), .first_err(firstA), .vec_count(vecA)
    );

    tv_sequencer #(.DUT_LAT(2), .ERR_W(2)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB),
        .rom_addr(romAddrB), .rom_data(romDataB),
        .dut_in(dutInB), .dut_out(dutOutB),
        .busy(busyB), .done(doneB), .pass(passB),
        .err_count(errB), .first_err(firstB), .vec_count(vecB)
    );

    // Units under test: a 32-bit adder of the two stimulus halves
    logic [31:0] uutB1, uutB2;
    assign dutOutA = dutInA[63:32] + dutInA[31:0];
    always @(posedge clk) begin
        uutB1 <= dutInB[63:32] + dutInB[31:0];
        uutB2 <= uutB1;
    end
    assign dutOutB = uutB2;

    rom_t romA, romB;
    always @(posedge clk) begin
        romDataA <= (romAddrA < 7'd100) ? romA[romAddrA] : '0;
        romDataB <= (romAddrB < 7'd100) ? romB[romAddrB] : '0;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        return {1'b1, a, b, e};
    endfunction

    // Expected outputs t cycles after the accepted start edge (t=1 is the first
    // cycle after it). Every vector takes 3+lat cycles: fetch, load, then lat+1
    // wait cycles; a sentinel costs 2 more cycles.
    function automatic obs_t model(input rom_t rom, input int lat, input int t,
                                   input int errMax, input logic [63:0] prevIn);
        obs_t m;
        int per, n, tot, k, ph, chkd, errs;
        logic [31:0] sum;
        m = '0;
        per = 3 + lat;
        n = 0;
        while (n < 100 && rom[n].v) n++;
        tot = n * per + ((n < 100) ? 2 : 0);
        if (t <= tot) begin
            k = (t - 1) / per;
            ph = (t - 1) % per;
            m.busy = 1'b1;
            m.addr = 7'(k);
            chkd = k;
            if (ph >= 2) m.din = rom[k].s;
            else if (k > 0) m.din = rom[k-1].s;
            else m.din = prevIn;
        end else begin
            m.done = 1'b1;
            chkd = n;
            m.addr = 7'((n < 100) ? n : 99);
            if (n > 0) m.din = rom[n-1].s;
            else m.din = prevIn;
        end
        errs = 0;
        for (int i = 0; i < chkd; i++) begin
            sum = rom[i].s[63:32] + rom[i].s[31:0];
            if (sum != rom[i].e) begin
                if (errs == 0) m.ferr = 7'(i);
                errs++;
            end
        end
        m.err = 16'((errs > errMax) ? errMax : errs);
        m.pass = m.done && (errs == 0);
        m.vcnt = 8'(chkd);
        return m;
    endfunction

    // Model state: which run is live, when it started, and its frozen ROM image
    logic runA = 1'b0, runB = 1'b0;
    int sA = 0, sB = 0;
    rom_t runRomA, runRomB;
    logic [63:0] prevA = '0, prevB = '0;
    obs_t lastA = '0, lastB = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            runA <= 1'b0;
            runB <= 1'b0;
        end else begin
            if (startA && !lastA.busy) begin
                runA <= 1'b1; sA <= cyc + 1; runRomA <= romA; prevA <= lastA.din;
            end
            if (startB && !lastB.busy) begin
                runB <= 1'b1; sB <= cyc + 1; runRomB <= romB; prevB <= lastB.din;
            end
        end
    end

    task automatic cmpObs(input string tag, input obs_t act, input obs_t exp);
        chk({tag, ".rom_addr"}, act.addr, exp.addr);
        chk({tag, ".dut_in"}, act.din, exp.din);
        chk({tag, ".busy"}, act.busy, exp.busy);
        chk({tag, ".done"}, act.done, exp.done);
        chk({tag, ".pass"}, act.pass, exp.pass);
        chk({tag, ".err_count"}, act.err, exp.err);
        chk({tag, ".first_err"}, act.ferr, exp.ferr);
        chk({tag, ".vec_count"}, act.vcnt, exp.vcnt);
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        obs_t ea, eb, oa, ob;
        if (!rst_n || !runA) ea = '0;
        else ea = model(runRomA, 0, cyc - sA + 1, 65535, prevA);
        if (!rst_n || !runB) eb = '0;
        else eb = model(runRomB, 2, cyc - sB + 1, 3, prevB);
        oa = {romAddrA, dutInA, busyA, doneA, passA, errA, firstA, vecA};
        ob = {romAddrB, dutInB, busyB, doneB, passB, {14'b0, errB}, firstB, vecB};
        cmpObs("A", oa, ea);
        cmpObs("B", ob, eb);
        chk("A.rom_addr_in_range", romAddrA < 7'd100, 1'b1);
        lastA <= ea;
        lastB <= eb;
    end

    task automatic pulseStart(input bit selB);
        @(posedge clk); #1;
        if (selB) startB = 1'b1; else startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        startB = 1'b0;
    endtask

    // Counts negedges until done (first negedge after the start edge is 1)
    task automatic waitDone(input bit selB, output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n++;
            if (selB ? doneB : doneA) break;
        end
        chk("done within budget", selB ? doneB : doneA, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        startA = 1'b0;
        startB = 1'b0;
        for (int i = 0; i < 100; i++) begin
            romA[i] = '0;
            romB[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset busy", busyA, 1'b0);
        chk("reset done", doneA, 1'b0);
        chk("reset pass", passA, 1'b0);
        chk("reset rom_addr", romAddrA, 7'd0);
        chk("reset dut_in", dutInA, 64'd0);
        chk("reset vec_count", vecB, 8'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Four correct adder vectors, sentinel at index 4
        romA[0] = mk(32'd1, 32'd2, 32'd3);
        romA[1] = mk(32'd10, 32'd20, 32'd30);
        romA[2] = mk(32'd1, 32'd3, 32'd4);
        romA[3] = mk(32'hFFFF_FFFF, 32'd2, 32'd1);
        pulseStart(0);
        waitDone(0, n);
        chk("A1 cycles to done", n, 1 + 4 * 3 + 2);
        chk("A1 vec_count", vecA, 8'd4);
        chk("A1 err_count", errA, 16'd0);
        chk("A1 pass", passA, 1'b1);
        chk("A1 dut_in held", dutInA, 64'hFFFF_FFFF_0000_0002);

        // Vector 2 expects 5, UUT gives 4
        romA[2].e = 32'd5;
        pulseStart(0);
        waitDone(0, n);
        chk("A2 cycles to done", n, 15);
        chk("A2 err_count", errA, 16'd1);
        chk("A2 first_err", firstA, 7'd2);
        chk("A2 pass", passA, 1'b0);

        // Sentinel at index 0: start edge, fetch edge, load edge
        romA[0].v = 1'b0;
        pulseStart(0);
        waitDone(0, n);
        chk("A3 cycles to done", n, 3);
        chk("A3 vec_count", vecA, 8'd0);
        chk("A3 pass", passA, 1'b1);

        // Full ROM, no sentinel; every seventh vector from 3 is wrong
        for (int i = 0; i < 100; i++) begin
            romA[i] = mk(32'(i), 32'(3 * i), (i % 7 == 3) ? 32'(4 * i + 1) : 32'(4 * i));
        end
        pulseStart(0);
        waitDone(0, n);
        chk("A4 cycles to done", n, 301);
        chk("A4 vec_count", vecA, 8'd100);
        chk("A4 rom_addr last", romAddrA, 7'd99);
        chk("A4 err_count", errA, 16'd14);
        chk("A4 first_err", firstA, 7'd3);

        // Registered UUT, two cycles of latency
        romB[0] = mk(32'd5, 32'd6, 32'd11);
        romB[1] = mk(32'd100, 32'd200, 32'd300);
        romB[2] = mk(32'd7, 32'd7, 32'd14);
        pulseStart(1);
        waitDone(1, n);
        chk("B1 cycles to done", n, 1 + 3 * 5 + 2);
        chk("B1 err_count", errB, 2'd0);
        chk("B1 vec_count", vecB, 8'd3);
        chk("B1 pass", passB, 1'b1);

        // Five failing vectors into a 2-bit counter: saturates at 3
        romB[0] = mk(32'd1, 32'd1, 32'd2);
        for (int i = 1; i < 6; i++) romB[i] = mk(32'(i), 32'(i), 32'd0);
        romB[6] = '0;
        pulseStart(1);
        waitDone(1, n);
        chk("B2 cycles to done", n, 33);
        chk("B2 err_count saturated", errB, 2'd3);
        chk("B2 first_err", firstB, 7'd1);
        chk("B2 vec_count", vecB, 8'd6);
        chk("B2 pass", passB, 1'b0);

        // Ten vectors (vector 1 wrong); ignored mid-run start, reset in vector 3 WAIT
        for (int i = 0; i < 10; i++) romA[i] = mk(32'(i), 32'(i), 32'(2 * i));
        romA[1].e = 32'd99;
        romA[10] = '0;
        pulseStart(0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 startA = 1'b1;
        @(posedge clk); #1 startA = 1'b0;
        @(negedge clk);
        chk("A5 start ignored rom_addr", romAddrA, 7'd1);
        chk("A5 start ignored vec_count", vecA, 8'd1);
        repeat (7) @(negedge clk);
        chk("A5 err before reset", errA, 16'd1);
        chk("A5 rom_addr before reset", romAddrA, 7'd3);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("A5 reset busy", busyA, 1'b0);
        chk("A5 reset rom_addr", romAddrA, 7'd0);
        chk("A5 reset dut_in", dutInA, 64'd0);
        chk("A5 reset err_count", errA, 16'd0);
        chk("A5 reset first_err", firstA, 7'd0);
        chk("A5 reset vec_count", vecA, 8'd0);
        chk("A5 reset done", doneB, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        pulseStart(0);
        @(negedge clk);
        chk("A5 restart rom_addr", romAddrA, 7'd0);
        chk("A5 restart busy", busyA, 1'b1);
        chk("A5 restart err_count", errA, 16'd0);
        chk("A5 restart vec_count", vecA, 8'd0);
        waitDone(0, n);
        // One negedge of the run was already consumed above: 1+10*3+2-1
        chk("A5 cycles to done", n, 32);
        chk("A5 err_count", errA, 16'd1);
        chk("A5 first_err", firstA, 7'd1);
        chk("A5 vec_count", vecA, 8'd10);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
